// File: rtl/serial_cmp_pkg.sv
// Shared types and constants for the bit-serial magnitude comparator.
package serial_cmp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int CMP_WIDTH_DEFAULT = 8;

  // A one-bit operand still needs a one-bit counter.
  function automatic int cnt_width(input int w);
    return (w <= 1) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/cmp_bit_slice.sv
// Single-bit unsigned comparator slice, shared across all bit positions.
module cmp_bit_slice (
  input  logic x,
  input  logic y,
  output logic gt,
  output logic eq,
  output logic lt
);

  assign gt = x & ~y;
  assign eq = ~(x ^ y);
  assign lt = ~x & y;

endmodule

// File: rtl/serial_mag_compare_ctrl.sv
// Bit-serial MSB-first magnitude comparator controller built on one shared slice.
// Optional macro SERIAL_CMP_EARLY_EXIT_EN finishes at the first differing bit.
module serial_mag_compare_ctrl
  import serial_cmp_pkg::*;
#(
  parameter int WIDTH = CMP_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             g,
  output logic             e,
  output logic             s
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e             state_q;
  logic [WIDTH-1:0]   a_sh_q, b_sh_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               dec_q, pg_q, ps_q;
  logic               busy_q, done_q, g_q, e_q, s_q;

  logic sl_gt, sl_eq, sl_lt;
  logic dec_d, pg_d, ps_d, last_d;

  cmp_bit_slice u_slice (
    .x  (a_sh_q[WIDTH-1]),
    .y  (b_sh_q[WIDTH-1]),
    .gt (sl_gt),
    .eq (sl_eq),
    .lt (sl_lt)
  );

  // Only the first deciding bit is captured; later bits cannot change the order.
  always_comb begin
    dec_d = dec_q;
    pg_d  = pg_q;
    ps_d  = ps_q;
    if (!dec_q && !sl_eq) begin
      dec_d = 1'b1;
      pg_d  = sl_gt;
      ps_d  = sl_lt;
    end
`ifdef SERIAL_CMP_EARLY_EXIT_EN
    last_d = (cnt_q == '0) || (!dec_q && !sl_eq);
`else
    last_d = (cnt_q == '0);
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      cnt_q   <= '0;
      dec_q   <= 1'b0;
      pg_q    <= 1'b0;
      ps_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      g_q     <= 1'b0;
      e_q     <= 1'b0;
      s_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            a_sh_q  <= a;
            b_sh_q  <= b;
            cnt_q   <= CNT_LAST;
            dec_q   <= 1'b0;
            pg_q    <= 1'b0;
            ps_q    <= 1'b0;
            g_q     <= 1'b0;
            e_q     <= 1'b0;
            s_q     <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          a_sh_q <= a_sh_q << 1;
          b_sh_q <= b_sh_q << 1;
          dec_q  <= dec_d;
          pg_q   <= pg_d;
          ps_q   <= ps_d;
          if (last_d) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            g_q     <= pg_d;
            s_q     <= ps_d;
            e_q     <= ~dec_d;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign g    = g_q;
  assign e    = e_q;
  assign s    = s_q;

endmodule

// File: tb/tb_serial_mag_compare_ctrl.sv
// Bench for serial_mag_compare_ctrl (WIDTH=8): transaction-level model plus directed vectors.
module tb_serial_mag_compare_ctrl;

  localparam int W = 8;
`ifdef SERIAL_CMP_EARLY_EXIT_EN
  localparam bit EE = 1'b1;
`else
  localparam bit EE = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic         busy, done, g, e, s;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  serial_mag_compare_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .g(g), .e(e), .s(s)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Edges from the accepting edge to the edge that raises done.
  function automatic int exp_lat(input logic [W-1:0] x, input logic [W-1:0] y);
    if (EE) begin
      for (int k = W - 1; k >= 0; k--)
        if (x[k] != y[k]) return W - k;
    end
    return W;
  endfunction

  // Transaction model: idle / running with an edge countdown / one done cycle.
  int       m_phase = 0;
  int       m_rem = 0;
  logic [2:0] m_res = 3'b000;
  logic     m_busy = 0, m_done = 0;
  logic [2:0] m_ges = 3'b000;

  always @(posedge clk) begin
    if (rst) begin
      m_phase = 0; m_rem = 0; m_busy = 0; m_done = 0; m_ges = 3'b000;
    end else if (m_phase == 0) begin
      m_done = 0;
      if (start) begin
        m_phase = 1;
        m_rem   = exp_lat(a, b);
        m_res   = (a > b) ? 3'b100 : (a == b) ? 3'b010 : 3'b001;
        m_busy  = 1;
        m_ges   = 3'b000;
      end
    end else if (m_phase == 1) begin
      m_rem--;
      if (m_rem == 0) begin
        m_phase = 2; m_busy = 0; m_done = 1; m_ges = m_res;
      end
    end else begin
      m_done = 0; m_phase = 0;
    end
  end

  always @(negedge clk) begin
    if (chk_en)
      check("cycle", {busy, done, g, e, s}, {m_busy, m_done, m_ges});
  end

  // Issue one compare and check flags and latency against hand-computed values.
  task automatic run_cmp(input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic [2:0] exp_ges, input int exp_edges, input string name);
    int i;
    bit seen;
    seen = 0;
    @(negedge clk);
    a = x; b = y; start = 1'b1;
    for (i = 1; i <= 40; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) begin seen = 1; break; end
    end
    check({name, "_seen"}, seen, 1);
    check({name, "_lat"}, i - 1, exp_edges);
    check({name, "_ges"}, {g, e, s}, exp_ges);
  endtask

  int pulses;
  int last_done, period_ok, nd;

  initial begin
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;
    repeat (5) @(negedge clk);
    check("idle_outs", {busy, done, g, e, s}, 0);

    run_cmp(8'hA5, 8'hA5, 3'b010, 8, "eq_a5");
    repeat (3) @(negedge clk);
    check("eq_hold", {busy, done, g, e, s}, 5'b00010);

    run_cmp(8'h80, 8'h7F, 3'b100, EE ? 1 : 8, "gt_80");
    run_cmp(8'h00, 8'h01, 3'b001, 8, "lt_01");

    // Ignored mid-run request while operand inputs toggle.
    @(negedge clk);
    a = 8'h42; b = 8'h43; start = 1'b1;
    pulses = 0;
    for (int i = 1; i <= 14; i++) begin
      @(negedge clk);
      if (done) begin
        pulses++;
        check("ign_ges", {g, e, s}, 3'b001);
      end
      if (i >= 2 && i <= 4) begin
        start = 1'b1; a = 8'h01; b = 8'hFF;
      end else if (i < 7) begin
        start = 1'b0; a = ~a; b = b ^ 8'h5A;
      end else begin
        start = 1'b0;
      end
    end
    check("ign_pulses", pulses, 1);

    // Reset three edges into a compare.
    @(negedge clk);
    a = 8'hF0; b = 8'h0F; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_outs", {busy, done, g, e, s}, 0);
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    check("rst_nodone", pulses, 0);
    run_cmp(8'h10, 8'h20, 3'b001, EE ? 3 : 8, "post_rst");

    // Back-to-back: next start in the idle cycle right after done.
    run_cmp(8'hFF, 8'h00, 3'b100, EE ? 1 : 8, "b2b_1");
    run_cmp(8'h7E, 8'h7E, 3'b010, 8, "b2b_2");

    // Start held high: one compare every WIDTH+2 cycles.
    @(negedge clk);
    a = 8'h33; b = 8'h33; start = 1'b1;
    last_done = -1; period_ok = 1; nd = 0;
    for (int i = 0; i < 45; i++) begin
      @(negedge clk);
      if (done) begin
        if (last_done >= 0 && (i - last_done) != W + 2) period_ok = 0;
        last_done = i;
        nd++;
      end
    end
    start = 1'b0;
    check("held_period", period_ok, 1);
    check("held_count", nd, 4);
    repeat (12) @(negedge clk);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_mag_compare_ctrl.md
Name: serial_mag_compare_ctrl

Overview:
- Bit-serial magnitude comparator controller for two unsigned WIDTH-bit operands.
- Latches both operands on start and shifts them MSB-first through a single 1-bit comparator slice, one bit per clock.
- Tracks the first deciding bit and reports a registered greater/equal/smaller result with a done pulse.
- Serves as the area-minimal comparator in code-converter and sort datapaths, where one shared slice replaces a WIDTH-bit parallel comparator.

Parameters:
- WIDTH, 8, operand width in bits; legal range is at least 1.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- start  input  1  request a compare; accepted only in IDLE.
- a  input  WIDTH  operand A, unsigned; sampled only on the accepting edge.
- b  input  WIDTH  operand B, unsigned; sampled only on the accepting edge.
- busy  output  1  high while a compare is in progress (RUN state).
- done  output  1  single-cycle pulse; result is valid from this cycle.
- g  output  1  result flag, a > b.
- e  output  1  result flag, a == b.
- s  output  1  result flag, a < b.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state=IDLE; busy=0, done=0, g=0, e=0, s=0; shift registers and bit counter cleared.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 at edge N loads a_sh<=a, b_sh<=b, cnt<=WIDTH-1, dec<=0.
  - Clears g/e/s to 0 and moves to RUN. busy=1 from edge N.
- RUN, at each edge:
  - Slice inputs are a_sh[WIDTH-1] and b_sh[WIDTH-1].
  - If dec=0 and the slice reports g or s: latch that flag into the pending result and set dec=1.
  - Shift a_sh and b_sh left by 1.
  - If cnt==0, go to DONE; otherwise cnt<=cnt-1.
- Latency: MSB is processed at edge N+1 and bit k at edge N+WIDTH-k. Without early exit, DONE is entered at edge N+WIDTH.
- DONE (exactly one cycle):
  - done=1, busy=0.
  - g/e/s drive the pending result; e=1 only if dec=0.
  - Next edge returns to IDLE.
- Result hold: g/e/s keep their value in IDLE until the next start is accepted. Exactly one of g/e/s is 1 after any completed compare.
- Ignored requests: start in RUN or DONE is ignored. There is no queueing; the requester must re-assert start in IDLE.
- Operand stability: changes on a/b while busy have no effect.
- Reset mid-operation: rst=1 in any state overrides everything at that edge and returns to reset values. No done pulse is emitted for the aborted compare.
- Simultaneous start and rst: rst wins.
- WIDTH=1: a single RUN cycle; done appears after edge N+1.
- cnt width: clog2(WIDTH), minimum 1 bit.

Optional Feature:
- Macro: SERIAL_CMP_EARLY_EXIT_EN.
- Defined:
  - In RUN, the first differing bit moves the FSM to DONE at that same edge.
  - Latency becomes WIDTH-k edges for first mismatch at bit k.
  - Equal operands still take WIDTH edges.
- Undefined:
  - Fixed latency of WIDTH edges for every operand pair, as described in Behaviour.
- Result values are identical in both builds.

Decomposition:
- Package serial_cmp_pkg:
  - State enum (IDLE, RUN, DONE).
  - Default width constant of 8.
  - Helper for counter width, clog2 with a minimum of 1.
- One sub-module, cmp_bit_slice:
  - Purely combinational 1-bit comparator with inputs x, y and outputs gt, eq, lt.
  - gt = x & ~y; eq = x xnor y; lt = ~x & y.
  - Instantiated once on the shift-register MSBs.

Test Plan (WIDTH=8):
- Reset, then idle 5 cycles -> busy=0, done=0, g=e=s=0 throughout.
- a=0xA5, b=0xA5, start at edge N -> busy during edges N..N+7; done after edge N+8; e=1, g=s=0; flags hold until next start. Same latency in both builds.
- a=0x80, b=0x7F -> g=1. Without macro, done after edge N+8; with macro, done after edge N+1. Also a=0x00, b=0x01 -> s=1, done after edge N+8 in both builds.
- Start while busy with new operands a=0x01, b=0xFF mid-run, plus a/b toggled every cycle during RUN -> original compare result unaffected; second request ignored; exactly one done pulse.
- rst=1 at edge N+3 of a compare -> all outputs 0 next cycle; no done pulse. Fresh start a=0x10, b=0x20 afterwards -> s=1 with normal latency.
- Back-to-back: start re-asserted in the cycle after done -> accepted, second result correct. Start held high continuously -> one compare per WIDTH+2 cycles.
